// File: rtl/pdm_capture_sched_pkg.sv
`default_nettype none
//============================================================================
// Module   : pdm_capture_sched_pkg
// Purpose  : Shared types, state encodings and arbiter helper for the
//            inverse-PDM capture scheduler.
// Revision : 1.0 - initial release
//============================================================================
package pdm_capture_sched_pkg;

    localparam int c_DUTY_W_DEF = 16;

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE    = 2'd0;
    localparam state_t c_CAPTURE = 2'd1;
    localparam state_t c_DRAIN   = 2'd2;
    localparam state_t c_DONE    = 2'd3;

    // Capture entry as seen with the default two-channel configuration.
    typedef struct packed {
        logic [0:0]              ch_id;
        logic [c_DUTY_W_DEF-1:0] duty;
    } cap_entry_t;

    // Round-robin distance of idx after ptr; the last-granted channel ranks last.
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        int d;
        d = (idx - ptr + n) % n;
        return (d == 0) ? n : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_capture_sched_fifo.sv
`default_nettype none
//============================================================================
// Module   : capture_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with exact registered
//            full/empty flags; push while full is accepted only with a pop.
// Revision : 1.0 - initial release
//============================================================================
module capture_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && !r_empty;
    assign w_push = push && (!r_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_AW+1)'(1);
                r_empty <= 1'b0;
                r_full  <= (r_count == (c_AW+1)'(DEPTH - 1));
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_AW+1)'(1);
                r_full  <= 1'b0;
                r_empty <= (r_count == (c_AW+1)'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty   = r_empty;
    assign full    = r_full;

endmodule
`default_nettype wire

// File: rtl/pdm_capture_sched.sv
`default_nettype none
//============================================================================
// Module   : pdm_capture_sched
// Purpose  : Collects per-window duty results from the recovery channels and
//            schedules them round-robin into a tagged capture FIFO.
// Revision : 1.0 - initial release
//============================================================================
module pdm_capture_sched
    import pdm_capture_sched_pkg::*;
#(
    parameter int  NUM_CH  = 2,
    parameter int  DUTY_W  = c_DUTY_W_DEF,
    parameter int  DEPTH   = 64,
    parameter int  CNT_W   = 16,
    localparam int CH_ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CNT_W-1:0]          num_smpls,
    input  logic [NUM_CH-1:0]         ch_done,
    input  logic [NUM_CH*DUTY_W-1:0]  ch_duty,
    input  logic                      rd_en,
    output logic [CH_ID_W+DUTY_W-1:0] rd_data,
    output logic                      empty,
    output logic                      full,
    output logic                      busy,
    output logic                      cap_done,
    output logic                      overrun
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_armed;
    logic [NUM_CH-1:0]   r_pending;
    logic [DUTY_W-1:0]   r_pend_duty [NUM_CH];
    logic [CH_ID_W-1:0]  r_rr_ptr;
    logic                r_overrun;

    logic                w_capture;
    logic                w_active;
    logic                w_gnt_valid;
    logic [CH_ID_W-1:0]  w_gnt_idx;
    logic [NUM_CH-1:0]   w_gnt_vec;
    int                  w_best_dist;
    logic                w_push;
    logic                w_drop;
    logic                w_start_ok;

    assign w_capture  = (r_state == c_CAPTURE);
    assign w_active   = (w_capture || r_state == c_DRAIN) && (r_cnt < r_target);
    assign w_start_ok = (r_state == c_IDLE) && start;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_vec   = '0;
        w_best_dist = NUM_CH + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_active && r_pending[i] &&
                rr_dist(i, int'(r_rr_ptr), NUM_CH) < w_best_dist) begin
                w_best_dist = rr_dist(i, int'(r_rr_ptr), NUM_CH);
                w_gnt_valid = 1'b1;
                w_gnt_idx   = CH_ID_W'(i);
            end
        end
        if (w_gnt_valid) w_gnt_vec[w_gnt_idx] = 1'b1;
    end

    // A grant against a full FIFO still succeeds when the head is popped this cycle.
    assign w_push = w_gnt_valid && (!full || rd_en);
    assign w_drop = w_gnt_valid && full && !rd_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_nxt = (num_smpls == '0) ? c_DONE : c_CAPTURE;
            c_CAPTURE: if (r_cnt == r_target || stop) w_state_nxt = c_DRAIN;
            c_DRAIN:   if (r_pending == '0 || r_cnt == r_target) w_state_nxt = c_DONE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_target  <= '0;
            r_cnt     <= '0;
            r_armed   <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_pend_duty[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_target  <= num_smpls;
                r_cnt     <= '0;
                r_armed   <= '0;
                r_pending <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_push)      r_cnt     <= r_cnt + CNT_W'(1);
                if (w_gnt_valid) r_rr_ptr  <= w_gnt_idx;
                if (w_drop)      r_overrun <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_capture && ch_done[i]) begin
                        if (!r_armed[i]) begin
                            r_armed[i] <= 1'b1;
                        end else begin
                            r_pending[i]   <= 1'b1;
                            r_pend_duty[i] <= ch_duty[i*DUTY_W +: DUTY_W];
                            if (r_pending[i] && !w_gnt_vec[i]) r_overrun <= 1'b1;
                        end
                    end else if (w_gnt_vec[i]) begin
                        r_pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CH_ID_W + DUTY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (rd_en),
        .wr_data ({w_gnt_idx, r_pend_duty[w_gnt_idx]}),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full)
    );

    assign busy     = (r_state != c_IDLE);
    assign cap_done = (r_state == c_DONE);
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture_sched.sv
`default_nettype none
//============================================================================
// Module   : tb_pdm_capture_sched
// Purpose  : Directed self-checking bench for pdm_capture_sched (DEPTH=4).
// Revision : 1.0 - initial release
//============================================================================
module tb_pdm_capture_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] num_smpls = '0;
    logic [1:0]  ch_done = '0;
    logic [31:0] ch_duty = '0;
    logic        rd_en = 1'b0;
    logic [16:0] rd_data;
    logic        empty;
    logic        full;
    logic        busy;
    logic        cap_done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pdm_capture_sched #(
        .NUM_CH (2),
        .DUTY_W (16),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .num_smpls (num_smpls),
        .ch_done   (ch_done),
        .ch_duty   (ch_duty),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .cap_done  (cap_done),
        .overrun   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1);
        ch_done = mask;
        ch_duty = {d1, d0};
        tick();
        ch_done = '0;
    endtask

    task automatic start_run(input logic [15:0] n);
        num_smpls = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (rd_data !== 17'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cap_done !== 1'b0) begin n_fail++; $display("FAIL reset_cap_done: got %b want 0", cap_done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        // mid-traffic reset
        start_run(16'd3);
        pulse(2'b01, 16'h1000, 16'h0);
        pulse(2'b01, 16'h1234, 16'h0);
        tick();
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset_empty: got %b want 0", empty); end
        rst = 1'b1;
        ch_done = 2'b11;
        tick();
        ch_done = '0;
        repeat (2) tick();
        rst = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midreset_empty: got %b want 1", empty); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (overrun !== 1'b0 || cap_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flags: got ovr=%b done=%b want 0 0", overrun, cap_done);
        end
    endtask

    task automatic test_single_channel();
        int done_cnt;
        start_run(16'd4);
        pulse(2'b01, 16'h4000, 16'h0);
        repeat (2047) tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_discard: empty got %b want 1", empty); end
        for (int k = 1; k <= 4; k++) begin
            pulse(2'b01, 16'h4000 + 16'(k * 16'h100), 16'h0);
            repeat (2047) tick();
        end
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (cap_done === 1'b1) done_cnt++;
            tick();
        end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL single_late_done: got %0d want 0 (done earlier)", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL single_full: got %b want 1", full); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (rd_data !== {1'b0, 16'h4000 + 16'(k * 16'h100)}) begin
                n_fail++; $display("FAIL single_entry%0d: got %h want %h", k, rd_data, {1'b0, 16'h4000 + 16'(k * 16'h100)});
            end
            pop();
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drained: empty got %b want 1", empty); end
    endtask

    task automatic test_cap_done_pulse();
        int done_cnt;
        start_run(16'd1);
        pulse(2'b10, 16'h0, 16'h0111);
        pulse(2'b10, 16'h0, 16'h0222);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cap_done === 1'b1) done_cnt++;
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulse_count: got %0d want 1", done_cnt); end
        n_checks++; if (rd_data !== {1'b1, 16'h0222}) begin n_fail++; $display("FAIL done_pulse_entry: got %h want %h", rd_data, {1'b1, 16'h0222}); end
        pop();
    endtask

    task automatic test_collision();
        start_run(16'd6);
        pulse(2'b11, 16'h0, 16'h0);
        repeat (3) tick();
        pulse(2'b10, 16'h0, 16'h1111);
        repeat (3) tick();
        n_checks++; if (rd_data !== {1'b1, 16'h1111}) begin n_fail++; $display("FAIL coll_single1: got %h want %h", rd_data, {1'b1, 16'h1111}); end
        pop();
        pulse(2'b11, 16'hA000, 16'hA001);
        tick();
        n_checks++; if (rd_data !== {1'b0, 16'hA000}) begin n_fail++; $display("FAIL coll1_first: got %h want %h", rd_data, {1'b0, 16'hA000}); end
        tick();
        pop();
        n_checks++; if (rd_data !== {1'b1, 16'hA001}) begin n_fail++; $display("FAIL coll1_second: got %h want %h", rd_data, {1'b1, 16'hA001}); end
        pop();
        pulse(2'b01, 16'h2222, 16'h0);
        repeat (2) tick();
        n_checks++; if (rd_data !== {1'b0, 16'h2222}) begin n_fail++; $display("FAIL coll_single0: got %h want %h", rd_data, {1'b0, 16'h2222}); end
        pop();
        pulse(2'b11, 16'hB000, 16'hB001);
        repeat (3) tick();
        n_checks++; if (rd_data !== {1'b1, 16'hB001}) begin n_fail++; $display("FAIL coll2_first: got %h want %h", rd_data, {1'b1, 16'hB001}); end
        pop();
        n_checks++; if (rd_data !== {1'b0, 16'hB000}) begin n_fail++; $display("FAIL coll2_second: got %h want %h", rd_data, {1'b0, 16'hB000}); end
        pop();
        repeat (6) tick();
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL coll_end: got busy=%b empty=%b want 0 1", busy, empty);
        end
    endtask

    task automatic test_overflow();
        int done_cnt;
        start_run(16'd10);
        pulse(2'b01, 16'hC000, 16'h0);
        repeat (2) tick();
        for (int k = 1; k <= 6; k++) begin
            pulse(2'b01, 16'hC000 + 16'(k), 16'h0);
            repeat (2) tick();
            if (k == 4) begin
                n_checks++; if (full !== 1'b1 || overrun !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_at_4: got full=%b ovr=%b want 1 0", full, overrun);
                end
            end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovf_overrun: got %b want 1", overrun); end
        n_checks++; if (busy !== 1'b1 || cap_done !== 1'b0) begin
            n_fail++; $display("FAIL ovf_running: got busy=%b done=%b want 1 0", busy, cap_done);
        end
        n_checks++; if (rd_data !== {1'b0, 16'hC001}) begin n_fail++; $display("FAIL ovf_head: got %h want %h", rd_data, {1'b0, 16'hC001}); end
        pulse(2'b01, 16'h7777, 16'h0);
        pop();
        n_checks++; if (full !== 1'b1 || rd_data !== {1'b0, 16'hC002}) begin
            n_fail++; $display("FAIL ovf_push_pop: got full=%b head=%h want 1 %h", full, rd_data, {1'b0, 16'hC002});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (cap_done === 1'b1) done_cnt++;
            tick();
        end
        n_checks++; if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ovf_stop: got done_cnt=%0d busy=%b want 1 0", done_cnt, busy);
        end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp_d;
            exp_d = (k == 3) ? 16'h7777 : 16'hC002 + 16'(k);
            n_checks++; if (rd_data !== {1'b0, exp_d}) begin n_fail++; $display("FAIL ovf_read%0d: got %h want %h", k, rd_data, {1'b0, exp_d}); end
            pop();
        end
    endtask

    task automatic test_early_stop();
        start_run(16'd100);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL stop_ovr_cleared: got %b want 0", overrun); end
        pulse(2'b10, 16'h0, 16'h5000);
        repeat (2) tick();
        stop = 1'b1;
        pulse(2'b10, 16'h0, 16'h5555);
        stop = 1'b0;
        n_checks++; if (busy !== 1'b1 || empty !== 1'b1) begin
            n_fail++; $display("FAIL stop_drain_entry: got busy=%b empty=%b want 1 1", busy, empty);
        end
        tick();
        n_checks++; if (rd_data !== {1'b1, 16'h5555}) begin n_fail++; $display("FAIL stop_drain_push: got %h want %h", rd_data, {1'b1, 16'h5555}); end
        tick();
        n_checks++; if (cap_done !== 1'b1) begin n_fail++; $display("FAIL stop_cap_done: got %b want 1", cap_done); end
        tick();
        n_checks++; if (busy !== 1'b0 || cap_done !== 1'b0) begin
            n_fail++; $display("FAIL stop_idle: got busy=%b done=%b want 0 0", busy, cap_done);
        end
        pulse(2'b11, 16'h6666, 16'h6666);
        repeat (3) tick();
        pop();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stop_ignored_done: empty got %b want 1", empty); end
    endtask

    task automatic test_edges();
        int done_cnt;
        start_run(16'd0);
        n_checks++; if (cap_done !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_run_done: got done=%b busy=%b want 1 1", cap_done, busy);
        end
        tick();
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL zero_run_idle: got busy=%b empty=%b want 0 1", busy, empty);
        end
        start_run(16'd2);
        pulse(2'b01, 16'h6000, 16'h0);
        pulse(2'b01, 16'h6001, 16'h0);
        tick();
        start_run(16'd0);
        repeat (2) tick();
        n_checks++; if (busy !== 1'b1 || cap_done !== 1'b0) begin
            n_fail++; $display("FAIL start_in_capture: got busy=%b done=%b want 1 0", busy, cap_done);
        end
        pulse(2'b01, 16'h6002, 16'h0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (cap_done === 1'b1) done_cnt++;
            tick();
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL edge_run_done: got %0d want 1", done_cnt); end
        n_checks++; if (rd_data !== {1'b0, 16'h6001}) begin n_fail++; $display("FAIL edge_entry0: got %h want %h", rd_data, {1'b0, 16'h6001}); end
        pop();
        n_checks++; if (rd_data !== {1'b0, 16'h6002}) begin n_fail++; $display("FAIL edge_entry1: got %h want %h", rd_data, {1'b0, 16'h6002}); end
        pop();
        pop();
        tick();
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 17'h0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL rd_on_empty: got empty=%b full=%b data=%h busy=%b ovr=%b want 1 0 0 0 0",
                               empty, full, rd_data, busy, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_cap_done_pulse();
        test_collision();
        test_overflow();
        test_early_stop();
        test_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
